// File: rtl/vec_pkg.sv
// Shared opcode and FSM state encodings for the vector execution unit.
// Included by the lane ALU and the top-level sequencer.
package vec_pkg;

    typedef enum logic [1:0] {
        OP_ADD   = 2'd0,
        OP_MUL   = 2'd1,
        OP_LOAD  = 2'd2,
        OP_STORE = 2'd3
    } opcode_t;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        EXEC = 3'd1,
        MEM  = 3'd2,
        WB   = 3'd3,
        DONE = 3'd4
    } state_t;

    // LOAD and STORE are the two opcodes with bit 1 set.
    function automatic logic is_mem_op(input opcode_t op);
        return op[1];
    endfunction

endpackage

// File: rtl/vec_lane_alu.sv
// One lane of the vector ALU: unsigned add (carry in hi) or full-width multiply.
// Purely combinational, no backpressure.
module vec_lane_alu
    import vec_pkg::*;
#(
    parameter int ELEM_W = 32
) (
    input  logic [ELEM_W-1:0] i_a,
    input  logic [ELEM_W-1:0] i_b,
    input  opcode_t           i_op,
    output logic [ELEM_W-1:0] o_lo,
    output logic [ELEM_W-1:0] o_hi
);

    logic [ELEM_W:0]     w_sum;
    logic [2*ELEM_W-1:0] w_prod;

    assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
    assign w_prod = {{ELEM_W{1'b0}}, i_a} * {{ELEM_W{1'b0}}, i_b};

    always_comb begin
        o_lo = w_sum[ELEM_W-1:0];
        o_hi = {{(ELEM_W-1){1'b0}}, w_sum[ELEM_W]};
        if (i_op == OP_MUL) begin
            o_lo = w_prod[ELEM_W-1:0];
            o_hi = w_prod[2*ELEM_W-1:ELEM_W];
        end
    end

endmodule

// File: rtl/vector_exec_unit.sv
// Vector execution unit: register file, lane ALUs and a memory handshake sequencer.
// ADD/MUL complete in 3 cycles; LOAD 2+k, STORE 1+k with k cycles waiting on mem_ack.
module vector_exec_unit
    import vec_pkg::*;
#(
    parameter int LANES     = 16,
    parameter int ELEM_W    = 32,
    parameter int NREGS     = 4,
    parameter int MEM_DEPTH = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [1:0]                opcode,
    input  logic [3:0]                rd,
    input  logic [3:0]                rs1,
    input  logic [3:0]                rs2,
    input  logic [7:0]                addr,
    output logic                      busy,
    output logic                      done,
    output logic                      err,
    output logic                      mem_req,
    output logic                      mem_we,
    output logic [7:0]                mem_addr,
    output logic [LANES*ELEM_W-1:0]   mem_wdata,
    input  logic                      mem_ack,
    input  logic [LANES*ELEM_W-1:0]   mem_rdata,
    input  logic [3:0]                dbg_sel,
    output logic [LANES*ELEM_W-1:0]   dbg_data
);

    localparam int VW    = LANES * ELEM_W;
    localparam int IDX_W = (NREGS > 1) ? $clog2(NREGS) : 1;
    localparam int ADDR_LIM = (MEM_DEPTH > 256) ? 256 : MEM_DEPTH;

    state_t            r_state;
    state_t            w_next;
    opcode_t           r_op;
    logic [IDX_W-1:0]  r_rd;
    logic [IDX_W-1:0]  r_rs1;
    logic [IDX_W-1:0]  r_rs2;
    logic [7:0]        r_addr;
    logic              r_illegal;
    logic [VW-1:0]     r_lo;
    logic [VW-1:0]     r_hi;
    logic [VW-1:0]     r_regs [NREGS];

    opcode_t           w_op_in;
    logic              w_cmd_illegal;
    logic              w_addr_ok;
    logic [IDX_W-1:0]  w_rd_next;
    logic [VW-1:0]     w_op_a;
    logic [VW-1:0]     w_op_b;
    logic [VW-1:0]     w_alu_lo;
    logic [VW-1:0]     w_alu_hi;
    logic              w_dbg_ok;

    function automatic logic idx_ok(input logic [3:0] idx);
        return {1'b0, idx} < 5'(NREGS);
    endfunction

    assign w_op_in   = opcode_t'(opcode);
    assign w_addr_ok = {1'b0, addr} < 9'(ADDR_LIM);

    // Only indices the opcode actually reads or writes take part in legality.
    always_comb begin
        w_cmd_illegal = 1'b0;
        case (w_op_in)
            OP_ADD, OP_MUL: w_cmd_illegal = !idx_ok(rd) || !idx_ok(rs1) || !idx_ok(rs2);
            OP_LOAD:        w_cmd_illegal = !idx_ok(rd) || !w_addr_ok;
            OP_STORE:       w_cmd_illegal = !idx_ok(rs1) || !w_addr_ok;
            default:        w_cmd_illegal = 1'b1;
        endcase
    end

    assign w_rd_next = (r_rd == IDX_W'(NREGS - 1)) ? '0 : r_rd + IDX_W'(1);
    assign w_op_a    = r_regs[r_rs1];
    assign w_op_b    = r_regs[r_rs2];

    genvar g;
    generate
        for (g = 0; g < LANES; g++) begin : g_lane
            vec_lane_alu #(.ELEM_W(ELEM_W)) u_alu (
                .i_a  (w_op_a[g*ELEM_W +: ELEM_W]),
                .i_b  (w_op_b[g*ELEM_W +: ELEM_W]),
                .i_op (r_op),
                .o_lo (w_alu_lo[g*ELEM_W +: ELEM_W]),
                .o_hi (w_alu_hi[g*ELEM_W +: ELEM_W])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    if (w_cmd_illegal)         w_next = DONE;
                    else if (is_mem_op(w_op_in)) w_next = MEM;
                    else                       w_next = EXEC;
                end
            end
            EXEC: w_next = WB;
            MEM: begin
                if (mem_ack) w_next = (r_op == OP_LOAD) ? WB : DONE;
            end
            WB:      w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        busy      = (r_state != IDLE);
        done      = (r_state == DONE);
        err       = (r_state == DONE) && r_illegal;
        mem_req   = (r_state == MEM);
        mem_we    = (r_state == MEM) && r_op[0];
        mem_addr  = (r_state == MEM) ? r_addr : 8'd0;
        mem_wdata = ((r_state == MEM) && (r_op == OP_STORE)) ? w_op_a : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_op      <= OP_ADD;
            r_rd      <= '0;
            r_rs1     <= '0;
            r_rs2     <= '0;
            r_addr    <= '0;
            r_illegal <= 1'b0;
            r_lo      <= '0;
            r_hi      <= '0;
            for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
        end else begin
            if ((r_state == IDLE) && start) begin
                r_op      <= w_op_in;
                r_rd      <= rd[IDX_W-1:0];
                r_rs1     <= rs1[IDX_W-1:0];
                r_rs2     <= rs2[IDX_W-1:0];
                r_addr    <= addr;
                r_illegal <= w_cmd_illegal;
            end
            if (r_state == EXEC) begin
                r_lo <= w_alu_lo;
                r_hi <= w_alu_hi;
            end
            // Load data parks in r_lo so WB has a single write source.
            if ((r_state == MEM) && mem_ack && (r_op == OP_LOAD)) begin
                r_lo <= mem_rdata;
            end
            if (r_state == WB) begin
                if (r_op == OP_LOAD) begin
                    r_regs[r_rd] <= r_lo;
                end else begin
                    // Second assignment wins if the two indices ever coincide.
                    r_regs[w_rd_next] <= r_hi;
                    r_regs[r_rd]      <= r_lo;
                end
            end
        end
    end

    assign w_dbg_ok = {1'b0, dbg_sel} < 5'(NREGS);
    assign dbg_data = w_dbg_ok ? r_regs[dbg_sel[IDX_W-1:0]] : '0;

endmodule

// File: tb/tb_vector_exec_unit.sv
// Scoreboarded bench for vector_exec_unit with LANES=4, ELEM_W=8, NREGS=4, MEM_DEPTH=32.
module tb_vector_exec_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  opcode = 2'd0;
    logic [3:0]  rd = 4'd0, rs1 = 4'd0, rs2 = 4'd0;
    logic [7:0]  addr = 8'd0;
    logic        busy, done, err, mem_req, mem_we;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = 32'd0;
    logic [3:0]  dbg_sel = 4'd0;
    logic [31:0] dbg_data;

    int total = 0;
    int bad = 0;

    typedef struct {
        bit err;
        int lat;
    } exp_t;
    exp_t exp_q[$];

    logic [31:0] m_regs [4];

    vector_exec_unit #(.LANES(4), .ELEM_W(8), .NREGS(4), .MEM_DEPTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .opcode(opcode),
        .rd(rd), .rs1(rs1), .rs2(rs2), .addr(addr),
        .busy(busy), .done(done), .err(err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .dbg_sel(dbg_sel), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] model_alu(input logic [1:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        logic [31:0] lo, hi;
        int x, y, r;
        lo = '0;
        hi = '0;
        for (int i = 0; i < 4; i++) begin
            x = int'(a[8*i +: 8]);
            y = int'(b[8*i +: 8]);
            r = (op == 2'd1) ? x * y : x + y;
            lo[8*i +: 8] = r[7:0];
            hi[8*i +: 8] = r[15:8];
        end
        return {hi, lo};
    endfunction

    task automatic check_regs(input string tag);
        for (int i = 0; i < 4; i++) begin
            dbg_sel = 4'(i);
            #1;
            total++;
            if (dbg_data !== m_regs[i]) begin
                bad++;
                $display("FAIL %s R%0d: got %h expected %h", tag, i, dbg_data, m_regs[i]);
            end
        end
        dbg_sel = 4'd9;
        #1;
        total++;
        if (dbg_data !== 32'd0) begin
            bad++;
            $display("FAIL %s dbg_out_of_range: got %h expected 0", tag, dbg_data);
        end
    endtask

    task automatic run_cmd(input string tag, input logic [1:0] op, input logic [3:0] rd_i,
                           input logic [3:0] rs1_i, input logic [3:0] rs2_i,
                           input logic [7:0] addr_i, input int k, input logic [31:0] rdata_i,
                           input bit exp_err, input bit poke);
        exp_t e, got_e;
        int lat, memc, exp_memc;
        bit seen_done;
        logic [31:0] exp_wdata;
        logic [63:0] r;

        e.err = exp_err;
        e.lat = exp_err ? 1 : (op < 2'd2) ? 3 : (op == 2'd2) ? k + 2 : k + 1;
        exp_q.push_back(e);
        exp_memc  = (exp_err || op < 2'd2) ? 0 : k;
        exp_wdata = m_regs[rs1_i[1:0]];
        if (!exp_err) begin
            if (op < 2'd2) begin
                r = model_alu(op, m_regs[rs1_i[1:0]], m_regs[rs2_i[1:0]]);
                m_regs[(rd_i[1:0] + 2'd1)] = r[63:32];
                m_regs[rd_i[1:0]] = r[31:0];
            end else if (op == 2'd2) begin
                m_regs[rd_i[1:0]] = rdata_i;
            end
        end

        start = 1'b1; opcode = op; rd = rd_i; rs1 = rs1_i; rs2 = rs2_i; addr = addr_i;
        tick();
        start = 1'b0;
        if (poke) begin
            start = 1'b1; opcode = 2'd2; rd = 4'd0; rs1 = 4'd3; rs2 = 4'd3; addr = 8'd3;
        end
        lat = 1; memc = 0; seen_done = 1'b0;
        while (lat <= 60 && !seen_done) begin
            if (mem_req) begin
                memc++;
                total++;
                if (mem_addr !== addr_i || mem_we !== op[0]) begin
                    bad++;
                    $display("FAIL %s mem_addr/we: got %h/%b expected %h/%b",
                             tag, mem_addr, mem_we, addr_i, op[0]);
                end
                if (op == 2'd3) begin
                    total++;
                    if (mem_wdata !== exp_wdata) begin
                        bad++;
                        $display("FAIL %s mem_wdata: got %h expected %h", tag, mem_wdata, exp_wdata);
                    end
                end
                if (memc == k) begin
                    mem_ack = 1'b1;
                    mem_rdata = rdata_i;
                end
            end
            if (done) begin
                seen_done = 1'b1;
                got_e = exp_q.pop_front();
                total++;
                if (err !== got_e.err || lat != got_e.lat) begin
                    bad++;
                    $display("FAIL %s done: err=%b lat=%0d expected err=%b lat=%0d",
                             tag, err, lat, got_e.err, got_e.lat);
                end
            end else begin
                tick();
                start = 1'b0;
                mem_ack = 1'b0;
                mem_rdata = 32'hDEAD_BEEF;
                lat++;
            end
        end
        if (!seen_done) begin
            void'(exp_q.pop_front());
            total++;
            bad++;
            $display("FAIL %s timeout: no done within %0d cycles, expected %0d", tag, lat, e.lat);
        end
        total++;
        if (memc != exp_memc) begin
            bad++;
            $display("FAIL %s mem_req_cycles: got %0d expected %0d", tag, memc, exp_memc);
        end
        tick();
        total++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL %s after_done: done=%b busy=%b expected 0/0", tag, done, busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) m_regs[i] = 32'd0;
        total++;
        if ({busy, done, err, mem_req, mem_we} !== 5'd0 || mem_addr !== 8'd0 || mem_wdata !== 32'd0) begin
            bad++;
            $display("FAIL reset_outputs: got b%b d%b e%b r%b w%b a%h wd%h expected all 0",
                     busy, done, err, mem_req, mem_we, mem_addr, mem_wdata);
        end
        check_regs("reset");
    endtask

    task automatic test_add();
        run_cmd("ld_r0", 2'd2, 4'd0, 4'd0, 4'd0, 8'd1, 1, 32'hFF01_8010, 1'b0, 1'b0);
        run_cmd("ld_r1", 2'd2, 4'd1, 4'd0, 4'd0, 8'd2, 2, 32'h0101_80F0, 1'b0, 1'b0);
        run_cmd("add", 2'd0, 4'd2, 4'd0, 4'd1, 8'd0, 1, 32'd0, 1'b0, 1'b0);
        check_regs("add");
        total++;
        if (m_regs[2] !== 32'h0002_0000 || m_regs[3] !== 32'h0100_0101) begin
            bad++;
            $display("FAIL add_model: R2=%h R3=%h expected 00020000/01000101", m_regs[2], m_regs[3]);
        end
    endtask

    task automatic test_mul();
        run_cmd("ld_r0m", 2'd2, 4'd0, 4'd0, 4'd0, 8'd7, 1, 32'hFF02_1000, 1'b0, 1'b0);
        run_cmd("ld_r1m", 2'd2, 4'd1, 4'd0, 4'd0, 8'd8, 1, 32'hFF03_1005, 1'b0, 1'b0);
        run_cmd("mul", 2'd1, 4'd3, 4'd0, 4'd1, 8'd0, 1, 32'd0, 1'b0, 1'b0);
        check_regs("mul");
    endtask

    task automatic test_load_store();
        run_cmd("load5", 2'd2, 4'd1, 4'd0, 4'd0, 8'd5, 3, 32'hA5A5_5A5A, 1'b0, 1'b0);
        run_cmd("store31", 2'd3, 4'd0, 4'd1, 4'd0, 8'd31, 2, 32'd0, 1'b0, 1'b0);
        check_regs("load_store");
    endtask

    task automatic test_illegal();
        run_cmd("ill_load", 2'd2, 4'd0, 4'd0, 4'd0, 8'd32, 1, 32'h1234_5678, 1'b1, 1'b0);
        run_cmd("ill_add", 2'd0, 4'd0, 4'd0, 4'd7, 8'd0, 1, 32'd0, 1'b1, 1'b0);
        run_cmd("ill_store", 2'd3, 4'd0, 4'd5, 4'd0, 8'd2, 1, 32'd0, 1'b1, 1'b0);
        check_regs("illegal");
    endtask

    task automatic test_back_to_back();
        run_cmd("b2b_add", 2'd0, 4'd2, 4'd1, 4'd3, 8'd0, 1, 32'd0, 1'b0, 1'b1);
        run_cmd("b2b_mul", 2'd1, 4'd3, 4'd2, 4'd2, 8'd0, 1, 32'd0, 1'b0, 1'b0);
        check_regs("back_to_back");
    endtask

    task automatic test_reset_mid();
        start = 1'b1; opcode = 2'd2; rd = 4'd2; addr = 8'd4;
        tick();
        start = 1'b0;
        tick();
        total++;
        if (mem_req !== 1'b1) begin
            bad++;
            $display("FAIL rst_mid_req: got %b expected 1", mem_req);
        end
        rst = 1'b1; mem_ack = 1'b1; mem_rdata = 32'h5555_AAAA; start = 1'b1;
        tick();
        rst = 1'b0; mem_ack = 1'b0; start = 1'b0;
        for (int i = 0; i < 4; i++) m_regs[i] = 32'd0;
        total++;
        if (mem_req !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid_after: req=%b busy=%b done=%b expected 0/0/0", mem_req, busy, done);
        end
        for (int c = 0; c < 3; c++) begin
            tick();
            total++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                bad++;
                $display("FAIL rst_mid_quiet: done=%b busy=%b expected 0/0", done, busy);
            end
        end
        check_regs("rst_mid");
    endtask

    initial begin
        tick();
        test_reset();
        test_add();
        test_mul();
        test_load_store();
        test_illegal();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
